// File: rtl/chacha_pkg.sv
// Shared ChaCha20 types: word, raw 512-bit state/pad, pad counter, and the
// keystream buffer fill states used by keystream_xor.
package chacha_pkg;

  localparam int PAD_WIDTH  = 512;
  localparam int WORD_WIDTH = 32;

  typedef logic [WORD_WIDTH-1:0] Word_t;
  typedef logic [PAD_WIDTH-1:0]  RawState_t;
  typedef logic [31:0]           PadCount_t;

  // Buffer occupancy: EMPTY waits for a pad, LOADED is XORing words from it.
  typedef enum logic {
    FILL_EMPTY  = 1'b0,
    FILL_LOADED = 1'b1
  } fill_state_t;

endpackage

// File: rtl/pad_word_sel.sv
// Combinational selector returning word idx of a keystream pad.
module pad_word_sel #(
  parameter int WORD_WIDTH = 32,
  parameter int PAD_WIDTH  = 512,
  parameter int IDX_W      = $clog2(PAD_WIDTH / WORD_WIDTH)
) (
  input  logic [PAD_WIDTH-1:0]  pad,
  input  logic [IDX_W-1:0]      idx,
  output logic [WORD_WIDTH-1:0] word
);

  assign word = pad[int'(idx) * WORD_WIDTH +: WORD_WIDTH];

endmodule

// File: rtl/keystream_xor.sv
// XORs buffered 512-bit keystream pads word-by-word onto a packet stream.
// Build option: KEYSTREAM_XOR_EOP_DISCARD_EN restarts each packet on a fresh pad.
module keystream_xor #(
  parameter int WORD_WIDTH = 32,
  parameter int PAD_WIDTH  = chacha_pkg::PAD_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [PAD_WIDTH-1:0]  ks_data,
  input  logic                  ks_valid,
  output logic                  ks_ready,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  in_eop,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  out_eop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output chacha_pkg::PadCount_t pads_used
);

  import chacha_pkg::*;

  localparam int WORDS = PAD_WIDTH / WORD_WIDTH;
  localparam int IDX_W = $clog2(WORDS);

`ifdef KEYSTREAM_XOR_EOP_DISCARD_EN
  localparam logic DISCARD = 1'b1;
`else
  localparam logic DISCARD = 1'b0;
`endif

  fill_state_t             fill_state;
  logic [PAD_WIDTH-1:0]    pad;
  logic [IDX_W-1:0]        idx;
  logic [WORD_WIDTH-1:0]   pad_word;
  logic                    pad_valid;
  logic                    ks_fire;
  logic                    in_fire;
  logic                    out_fire;
  logic                    last;
  logic                    retire;

  pad_word_sel #(
    .WORD_WIDTH (WORD_WIDTH),
    .PAD_WIDTH  (PAD_WIDTH),
    .IDX_W      (IDX_W)
  ) u_sel (
    .pad  (pad),
    .idx  (idx),
    .word (pad_word)
  );

  // Every port pair uses valid/ready: a transfer happens on a clock edge where
  // both are high; valid never waits on ready, and in_ready never looks at in_valid.
  always_comb begin
    pad_valid = (fill_state == FILL_LOADED);
    in_ready  = pad_valid && (!out_valid || out_ready);
    ks_fire   = ks_valid && ks_ready;
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
    last      = (idx == IDX_W'(WORDS - 1));
    retire    = in_fire && (last || (in_eop && DISCARD));
    // Accepting the next pad while the final word drains avoids a refill bubble.
    ks_ready  = !pad_valid || retire;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fill_state <= FILL_EMPTY;
      pad        <= '0;
      idx        <= '0;
      out_data   <= '0;
      out_eop    <= 1'b0;
      out_valid  <= 1'b0;
      pads_used  <= '0;
    end else begin
      if (in_fire) begin
        out_data  <= in_data ^ pad_word;
        out_eop   <= in_eop;
        out_valid <= 1'b1;
        idx       <= retire ? '0 : idx + 1'b1;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end

      if (retire) begin
        pads_used <= pads_used + 32'd1;
      end

      case (fill_state)
        FILL_EMPTY: begin
          if (ks_fire) begin
            pad        <= ks_data;
            idx        <= '0;
            fill_state <= FILL_LOADED;
          end
        end
        FILL_LOADED: begin
          if (retire) begin
            if (ks_fire) begin
              pad <= ks_data;
            end else begin
              fill_state <= FILL_EMPTY;
            end
          end
        end
        default: fill_state <= FILL_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_keystream_xor.sv
// Self-checking bench for keystream_xor: directed cases plus randomized traffic
// checked against a pad-queue reference model.
module tb_keystream_xor;

  localparam int WW    = 32;
  localparam int PW    = 512;
  localparam int WORDS = PW / WW;

`ifdef KEYSTREAM_XOR_EOP_DISCARD_EN
  localparam bit DISCARD = 1'b1;
`else
  localparam bit DISCARD = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [PW-1:0] ks_data = '0;
  logic          ks_valid = 1'b0;
  logic          ks_ready;
  logic [WW-1:0] in_data = '0;
  logic          in_eop = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [WW-1:0] out_data;
  logic          out_eop;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   pads_used;

  keystream_xor #(.WORD_WIDTH(WW), .PAD_WIDTH(PW)) dut (
    .clock     (clock),
    .reset     (reset),
    .ks_data   (ks_data),
    .ks_valid  (ks_valid),
    .ks_ready  (ks_ready),
    .in_data   (in_data),
    .in_eop    (in_eop),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_eop   (out_eop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pads_used (pads_used)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  int pass_count  = 0;
  int total_count = 0;

  logic [WW:0]   exp_q[$];
  logic [WW-1:0] pad_words[WORDS];
  bit            loaded = 1'b0;
  int            pos = 0;
  bit            out_pending = 1'b0;
  int unsigned   retired = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_count++;
    if (got === exp) pass_count++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: a pad is a list of 16 words consumed in order; a packet end
  // optionally abandons the rest. Observed at negedge for the upcoming edge.
  always @(negedge clock) begin
    bit e_in_ready, e_retire, e_ks_ready;
    logic [WW:0] e;
    if (reset) begin
      loaded = 1'b0;
      pos = 0;
      out_pending = 1'b0;
      retired = 0;
      exp_q.delete();
    end else begin
      e_in_ready = loaded && (!out_pending || out_ready);
      e_retire   = in_valid && e_in_ready && (pos == WORDS - 1 || (in_eop && DISCARD));
      e_ks_ready = !loaded || e_retire;
      check("in_ready", in_ready, e_in_ready);
      check("ks_ready", ks_ready, e_ks_ready);
      check("out_valid", out_valid, out_pending);
      check("pads_used", pads_used, retired);
      if (out_pending && out_ready) begin
        check("out_q_nonempty", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("out_data", out_data, e[WW-1:0]);
          check("out_eop", out_eop, e[WW]);
        end
      end
      if (in_valid && e_in_ready) begin
        exp_q.push_back({in_eop, in_data ^ pad_words[pos]});
        if (e_retire) begin
          pos = 0;
          loaded = 1'b0;
          retired++;
        end else begin
          pos++;
        end
        out_pending = 1'b1;
      end else if (out_pending && out_ready) begin
        out_pending = 1'b0;
      end
      if (ks_valid && e_ks_ready) begin
        for (int w = 0; w < WORDS; w++) pad_words[w] = ks_data[w*WW +: WW];
        loaded = 1'b1;
        pos = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    ks_valid = 1'b0;
    in_valid = 1'b0;
    in_eop   = 1'b0;
  endtask

  function automatic logic [PW-1:0] rand_pad();
    logic [PW-1:0] p;
    for (int w = 0; w < WORDS; w++) p[w*WW +: WW] = $urandom;
    return p;
  endfunction

  task automatic do_reset(input string tag);
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle();
    out_ready = 1'b1;
    #1;
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_data"}, out_data, '0);
    check({tag, "_out_eop"}, out_eop, 1'b0);
    check({tag, "_ks_ready"}, ks_ready, 1'b1);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_pads_used"}, pads_used, '0);
  endtask

  task automatic drain(input string tag);
    idle();
    out_ready = 1'b1;
    repeat (3) step();
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [PW-1:0] p;
    step();
    do_reset("reset");

    // Single pad: word i = 0x01010101*i onto all-ones data.
    for (int w = 0; w < WORDS; w++) p[w*WW +: WW] = 32'h0101_0101 * w;
    ks_data = p;
    ks_valid = 1'b1;
    step();
    ks_valid = 1'b0;
    for (int i = 0; i < WORDS; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hFFFF_FFFF;
      in_eop   = (i == WORDS - 1);
      step();
    end
    drain("single");
    check("single_pads_used", pads_used, 32'd1);

    // Back-to-back pads with no bubbles.
    do_reset("b2b_reset");
    ks_data = rand_pad();
    ks_valid = 1'b1;
    step();
    for (int k = 0; k < 3 * WORDS; k++) begin
      ks_valid = 1'b1;
      ks_data  = rand_pad();
      in_valid = 1'b1;
      in_eop   = 1'b0;
      in_data  = $urandom;
      #1;
      check("b2b_no_bubble", in_ready, 1'b1);
      check("b2b_ks_pulse", ks_ready, (k % WORDS) == WORDS - 1);
      step();
    end
    idle();
    check("b2b_pads_used", pads_used, 32'd3);
    drain("b2b");

    // Short packet followed by a 3-word packet.
    do_reset("short_reset");
    for (int i = 0; i < 1 + 5 + 3; i++) begin
      ks_valid = 1'b1;
      ks_data  = rand_pad();
      in_valid = (i != 0);
      in_data  = $urandom;
      in_eop   = (i == 5) || (i == 8);
      step();
    end
    idle();
    check("short_pads_used", pads_used, DISCARD ? 32'd2 : 32'd0);
    drain("short");

    // Randomized traffic: 1010 backpressure, then random backpressure.
    do_reset("rand_reset");
    for (int c = 0; c < 400; c++) begin
      ks_valid  = ($urandom_range(0, 9) < 7);
      ks_data   = rand_pad();
      in_valid  = ($urandom_range(0, 9) < 8);
      in_data   = $urandom;
      in_eop    = ($urandom_range(0, 5) == 0);
      out_ready = (c < 200) ? c[0] : ($urandom_range(0, 2) != 0);
      #1;
      if (out_valid && !out_ready) check("bp_in_ready_low", in_ready, 1'b0);
      step();
    end
    drain("rand");

    // Reset after 7 words of a pad, then restart on a new pad.
    do_reset("mid_reset0");
    ks_data = rand_pad();
    ks_valid = 1'b1;
    step();
    ks_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      in_eop   = 1'b0;
      step();
    end
    do_reset("mid_reset");
    ks_data = rand_pad();
    ks_valid = 1'b1;
    step();
    ks_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      in_eop   = (i == 9);
      step();
    end
    drain("after_reset");

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule

// File: doc/keystream_xor.md
# keystream_xor

Avalon-ST consumer for the ChaCha20 keystream generator. It accepts 512-bit pads on a keystream sink and buffers one pad. It XORs the pad, one 32-bit word at a time, onto a packetised data stream to produce ciphertext or plaintext on a registered Avalon-ST source. It sits between the ChaCha20 core's `st_*` source and the DMA datapath, and sustains one word per clock with no refill bubble.

## Interface

Parameters:
- `WORD_WIDTH`, default 32: data word width. Must be 32, 64 or 128, so it divides 512.
- `PAD_WIDTH`, default 512: keystream pad width. Fixed at 512.

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `ks_data`  in  PAD_WIDTH  keystream pad. Word i is `ks_data[i*WORD_WIDTH +: WORD_WIDTH]`.
- `ks_valid`  in  1  pad valid.
- `ks_ready`  out  1  pad accepted this cycle when `ks_valid` is also high.
- `in_data`  in  WORD_WIDTH  input message word.
- `in_eop`  in  1  last word of the packet.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  input word accepted this cycle when `in_valid` is also high.
- `out_data`  out  WORD_WIDTH  registered `in_data ^ pad word`.
- `out_eop`  out  1  registered copy of `in_eop`.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  downstream accepts the output word.
- `pads_used`  out  32  count of pads retired, wrapping at 2^32.

## Operation

- Internal state:
  - `pad` register and `pad_valid` flag.
  - Word index `idx`, width log2(PAD_WIDTH/WORD_WIDTH).
  - Output register stage.
- Handshake strobes:
  - `ks_fire = ks_valid && ks_ready`.
  - `in_fire = in_valid && in_ready`.
  - `out_fire = out_valid && out_ready`.
- `last = (idx == PAD_WIDTH/WORD_WIDTH-1)`.
- `retire = in_fire && (last || (in_eop && discard))`. `discard` is defined under Configuration.
- `in_ready = pad_valid && (!out_valid || out_ready)`. There is no combinational path from `in_valid` to `in_ready`.
- `ks_ready = !pad_valid || retire`. This allows a back-to-back refill in the cycle the final word is consumed.
- On `in_fire`:
  - `out_data <= in_data ^ pad[idx*WORD_WIDTH +: WORD_WIDTH]`.
  - `out_eop <= in_eop`.
  - `out_valid <= 1`.
  - `idx <= idx+1`, or 0 on retire.
- On `out_fire` without `in_fire`: `out_valid <= 0`.
- On retire:
  - `pad_valid <= 0`, unless `ks_fire` occurs in the same cycle, in which case load the new pad and set `pad_valid <= 1`.
  - `pads_used <= pads_used+1`.
- On `ks_fire` with `!pad_valid`: `pad <= ks_data`, `pad_valid <= 1`, `idx <= 0`.
- States are implied by `pad_valid`:
  - EMPTY (`pad_valid=0`) goes to LOADED on `ks_fire`.
  - LOADED stays LOADED on retire+`ks_fire`.
  - LOADED goes to EMPTY on retire without `ks_fire`.
- Words of one pad are never reused. Each pad word is XORed exactly once.

## Timing

- Reset values:
  - `out_valid=0`, `out_data=0`, `out_eop=0`.
  - `pads_used=0`, `pad_valid=0`, `idx=0`.
  - `ks_ready=1` and `in_ready=0` from the cycle after reset.
- `reset` asserted mid-packet discards the buffered pad and output word; the stream restarts cleanly.
- Latency is 1 cycle: the word accepted at edge N appears on `out_data` after edge N.
- Throughput is 1 word/cycle while keystream keeps up. A pad loaded at edge N enables `in_ready` from cycle N+1.
- When `out_valid && !out_ready`, `in_ready=0` and the output register holds.
- Simultaneous `out_fire` and `in_fire`: the output register reloads and `out_valid` stays 1.
- `pads_used` wraps from 0xFFFFFFFF to 0.

## Configuration

- Macro: `KEYSTREAM_XOR_EOP_DISCARD_EN`.
- Defined: `discard = 1`. Any pad words left after an `in_eop` word are dropped, so every packet starts on a fresh pad at word 0, matching one ChaCha20 block counter per packet boundary.
- Undefined: `discard = 0`. `in_eop` only passes through to `out_eop`, and the keystream continues seamlessly into the next packet.

## Structure

- Shared package `chacha_pkg` holds:
  - `Word_t`
  - `PAD_WIDTH`
  - `RawState_t` (512-bit pad type)
  - `PadCount_t` (32-bit)
- The ChaCha20 core imports the same package.
- One sub-module, `pad_word_sel`, is a combinational mux selecting word `idx` from the pad.
- All control logic stays in `keystream_xor`.

## Test plan

- **Single pad:** set ks word i = 0x01010101*i, send 16 words of 0xFFFFFFFF with eop on word 15. Required: `out_data` word i = ~(0x01010101*i), `out_eop` on word 15 only, `pads_used=1`.
- **Back-to-back pads:** hold `ks_valid` and `in_valid` high for 48 words with `out_ready` held high. Required: zero bubbles, `ks_ready` pulses exactly on words 15, 31 and 47, `pads_used=3`.
- **Short packet, discard defined:** send a 5-word eop packet followed by a 3-word packet. Required: the second packet uses words 0–2 of pad 2, `pads_used=2` after it.
- **Short packet, discard undefined:** same stimulus as the previous case. Required: the second packet uses words 5–7 of pad 1, `pads_used=0`.
- **Backpressure:** toggle `out_ready` 1010… during the stream. Required: `in_ready` is low whenever `out_valid && !out_ready`, and the output sequence equals the reference XOR with no loss or duplication.
- **Reset mid-pad:** assert `reset` after 7 words. Required: `out_valid=0` and `ks_ready=1` next cycle, and the next pad's word 0 applies to the first new input word.
